// File: rtl/board_pkg.sv
// Shared types for the board game controller: cell codes, FSM phases and
// the boat-count clamp.
package board_pkg;

   typedef enum logic [1:0] {
      CELL_EMPTY = 2'd0,
      CELL_BOAT  = 2'd1,
      CELL_HIT   = 2'd2,
      CELL_MISS  = 2'd3
   } cell_t;

   typedef enum logic [1:0] {
      PH_SETUP = 2'd0,
      PH_PLACE = 2'd1,
      PH_PLAY  = 2'd2,
      PH_DONE  = 2'd3
   } phase_t;

   function automatic logic [2:0] clamp(input logic [2:0] v,
                                        input logic [2:0] lo,
                                        input logic [2:0] hi);
      if (v < lo)      return lo;
      else if (v > hi) return hi;
      else             return v;
   endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for one level button.
// o_rise is high for exactly one cycle per press, however long it is held.
module btn_edge (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_rise
);

   logic [1:0] r_sync;
   logic       r_prev;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_btn};
         r_prev <= r_sync[1];
      end
   end

   assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/board_ctrl.sv
// Single-player battleship-style board: boat placement, shooting, cursor
// movement and a registered display read port over a register-array board.
module board_ctrl
   import board_pkg::*;
#(
   parameter int BOARD_N   = 5,
   parameter int MAX_BOATS = 5,
   parameter int WRAP      = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       direction,
   input  logic                       move_h,
   input  logic                       move_v,
   input  logic                       place_boat,
   input  logic                       fire,
   input  logic [2:0]                 amount_boats,
   input  logic [$clog2(BOARD_N)-1:0] rd_x,
   input  logic [$clog2(BOARD_N)-1:0] rd_y,
   output logic [1:0]                 rd_cell,
   output logic [$clog2(BOARD_N)-1:0] cursor_x,
   output logic [$clog2(BOARD_N)-1:0] cursor_y,
   output logic [1:0]                 phase,
   output logic [2:0]                 boats_left,
   output logic                       shot_valid,
   output logic                       shot_hit,
   output logic                       game_over
);

   localparam int              CW   = $clog2(BOARD_N);
   localparam int unsigned     N_U  = BOARD_N;
   localparam logic [CW-1:0]   LAST = CW'(BOARD_N - 1);

   logic w_mh_e, w_mv_e, w_place_e, w_fire_e;

   btn_edge u_mh    (.i_clk(clock), .i_rst_n(reset), .i_btn(move_h),     .o_rise(w_mh_e));
   btn_edge u_mv    (.i_clk(clock), .i_rst_n(reset), .i_btn(move_v),     .o_rise(w_mv_e));
   btn_edge u_place (.i_clk(clock), .i_rst_n(reset), .i_btn(place_boat), .o_rise(w_place_e));
   btn_edge u_fire  (.i_clk(clock), .i_rst_n(reset), .i_btn(fire),       .o_rise(w_fire_e));

   phase_t        r_state, w_state_nxt;
   cell_t         r_cells [BOARD_N][BOARD_N];
   cell_t         w_cur_cell;
   logic [CW-1:0] r_cur_x, r_cur_y;
   logic [2:0]    r_boats_left, r_target;
   logic [1:0]    r_rd_cell;
   logic          r_shot_valid, r_shot_hit;
   logic          w_setup_go, w_reload, w_do_place, w_do_fire;

   function automatic logic [CW-1:0] step(input logic [CW-1:0] c, input logic dir);
      if (dir) begin
         if (c == LAST) return (WRAP != 0) ? '0 : c;
         else           return c + CW'(1);
      end else begin
         if (c == '0)   return (WRAP != 0) ? LAST : c;
         else           return c - CW'(1);
      end
   endfunction

   assign w_cur_cell = r_cells[r_cur_y][r_cur_x];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= PH_SETUP;
      else        r_state <= w_state_nxt;
   end

   // boats_left==0 is checked first so a late press in the exit cycle is dropped
   always_comb begin
      w_state_nxt = r_state;
      w_setup_go  = 1'b0;
      w_reload    = 1'b0;
      w_do_place  = 1'b0;
      w_do_fire   = 1'b0;
      unique case (r_state)
         PH_SETUP: if (w_place_e) begin
            w_setup_go  = 1'b1;
            w_state_nxt = PH_PLACE;
         end
         PH_PLACE: if (r_boats_left == '0) begin
            w_reload    = 1'b1;
            w_state_nxt = PH_PLAY;
         end else if (w_place_e && w_cur_cell == CELL_EMPTY) begin
            w_do_place = 1'b1;
         end
         PH_PLAY: if (r_boats_left == '0) begin
            w_state_nxt = PH_DONE;
         end else if (w_fire_e && (w_cur_cell == CELL_EMPTY || w_cur_cell == CELL_BOAT)) begin
            w_do_fire = 1'b1;
         end
         PH_DONE: ;
         default: w_state_nxt = PH_SETUP;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int unsigned y = 0; y < N_U; y++)
            for (int unsigned x = 0; x < N_U; x++)
               r_cells[y][x] <= CELL_EMPTY;
         r_cur_x      <= '0;
         r_cur_y      <= '0;
         r_boats_left <= '0;
         r_target     <= '0;
         r_rd_cell    <= '0;
         r_shot_valid <= 1'b0;
         r_shot_hit   <= 1'b0;
      end else begin
         if (32'(rd_x) < N_U && 32'(rd_y) < N_U) r_rd_cell <= r_cells[rd_y][rd_x];
         else                                    r_rd_cell <= CELL_EMPTY;

         if (w_mh_e) r_cur_x <= step(r_cur_x, direction);
         if (w_mv_e) r_cur_y <= step(r_cur_y, direction);

         r_shot_valid <= w_do_fire;
         r_shot_hit   <= w_do_fire && (w_cur_cell == CELL_BOAT);

         if (w_setup_go) begin
            r_target     <= clamp(amount_boats, 3'd1, 3'(MAX_BOATS));
            r_boats_left <= clamp(amount_boats, 3'd1, 3'(MAX_BOATS));
         end
         if (w_reload) r_boats_left <= r_target;
         if (w_do_place) begin
            r_cells[r_cur_y][r_cur_x] <= CELL_BOAT;
            r_boats_left              <= r_boats_left - 3'd1;
         end
         if (w_do_fire) begin
            if (w_cur_cell == CELL_BOAT) begin
               r_cells[r_cur_y][r_cur_x] <= CELL_HIT;
               r_boats_left              <= r_boats_left - 3'd1;
            end else begin
               r_cells[r_cur_y][r_cur_x] <= CELL_MISS;
            end
         end
      end
   end

   assign rd_cell    = r_rd_cell;
   assign cursor_x   = r_cur_x;
   assign cursor_y   = r_cur_y;
   assign phase      = r_state;
   assign boats_left = r_boats_left;
   assign shot_valid = r_shot_valid;
   assign shot_hit   = r_shot_hit;
   assign game_over  = (r_state == PH_DONE);

endmodule
